// File: rtl/ls_sequencer_if.sv
// Command port of the load-store sequencer: one LOAD/STORE descriptor per transfer.
// Latency: none (plain wires); a transfer happens when cmd_valid & cmd_ready at a rising edge.
// Backpressure: the slave drops cmd_ready while its command queue is full.
//
// Signals:
//   cmd_valid  master -> slave  descriptor present this cycle
//   cmd_ready  slave  -> master slave can accept a descriptor
//   cmd_op     master -> slave  0 = LOAD, 1 = STORE
//   cmd_rd     master -> slave  LOAD destination / STORE data source register
//   cmd_rb     master -> slave  base-address register
//   cmd_off    master -> slave  unsigned address offset
interface ls_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_op;
    logic [4:0] cmd_rd;
    logic [4:0] cmd_rb;
    logic [4:0] cmd_off;

    // Command source (decode unit, bench).
    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_rd,
        output cmd_rb,
        output cmd_off,
        input  cmd_ready
    );

    // Command sink (the sequencer).
    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_rd,
        input  cmd_rb,
        input  cmd_off,
        output cmd_ready
    );
endinterface

// File: rtl/ls_sequencer.sv
// Load-store sequencer: queues LOAD/STORE commands and steps each through SETUP -> EXEC -> DONE.
// Latency: push at edge T0 -> SETUP T1 -> EXEC T2 -> write at T3 -> done during T3..T4; 1 cmd / 3 cycles.
// Backpressure: cmd_ready = !full from registered state; halt stalls the queue head, never the active command.
//
// Ports:
//   CLK, RST       clock and synchronous active-high reset
//   cmd            command port (ls_sequencer_if.slave): cmd_valid/cmd_ready, cmd_op/rd/rb/off
//   halt           blocks the next pop from the queue; the command in flight still completes
//   Ra, Rb, C, Rw  datapath selects (STORE data source, base, offset, register write target)
//   WE_RF, WE_MEM  register-file / data-memory write enables, asserted only in EXEC
//   busy           command in SETUP, EXEC or DONE
//   done, done_op  one-cycle completion pulse and the op of the finishing command
//   retired        wrapping count of completed commands
module ls_sequencer #(
    parameter int DEPTH = 4,    // command queue entries; power of two, >= 2
    parameter int CNTW  = 16    // width of the retired-command counter
) (
    input  logic            CLK,
    input  logic            RST,
    ls_sequencer_if.slave   cmd,
    input  logic            halt,
    output logic [4:0]      Ra,
    output logic [4:0]      Rb,
    output logic [4:0]      C,
    output logic [4:0]      Rw,
    output logic            WE_RF,
    output logic            WE_MEM,
    output logic            busy,
    output logic            done,
    output logic            done_op,
    output logic [CNTW-1:0] retired
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic       op;     // 0 = LOAD, 1 = STORE
        logic [4:0] rd;
        logic [4:0] rb;
        logic [4:0] off;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_EXEC  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Command queue
    // ------------------------------------------------------------------
    cmd_t          fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    cmd_t          in_cmd;
    cmd_t          head;

    assign in_cmd = '{op: cmd.cmd_op, rd: cmd.cmd_rd, rb: cmd.cmd_rb, off: cmd.cmd_off};

    assign fifo_full  = (fifo_cnt == FULL_CNT);
    assign fifo_empty = (fifo_cnt == '0);

    // Ready comes only from the registered occupancy, so a pop in the same
    // cycle never opens a slot combinationally. As a consequence a push can
    // never land on a full queue; a push and a pop together leave the count
    // unchanged.
    assign cmd.cmd_ready = !fifo_full;
    assign push          = cmd.cmd_valid && !fifo_full;
    assign head          = fifo_mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap on their own.
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (AW + 1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW + 1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Storage needs no reset: entries are only read behind the write pointer.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_cmd;
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    state_t state;
    state_t state_nxt;
    cmd_t   cur;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            cur     <= '0;
            retired <= '0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                cur <= head;
            end
            if (state == S_DONE) begin
                retired <= retired + CNTW'(1);
            end
        end
    end

    // A new command is taken only from IDLE or DONE; this is the single
    // point where halt acts, so a command already in flight always finishes.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (!fifo_empty && !halt) begin
                    pop       = 1'b1;
                    state_nxt = S_SETUP;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_SETUP: state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath controls. Selects stay valid through DONE so the datapath
    // sees a stable command until the next pop replaces cur. The write
    // enables are masked by RST so a reset landing on EXEC never commits.
    always_comb begin
        Ra      = '0;
        Rb      = '0;
        C       = '0;
        Rw      = '0;
        WE_RF   = 1'b0;
        WE_MEM  = 1'b0;
        busy    = (state != S_IDLE);
        done    = (state == S_DONE);
        done_op = cur.op;
        if (state != S_IDLE) begin
            Ra = cur.rd;
            Rb = cur.rb;
            C  = cur.off;
            Rw = cur.rd;
        end
        if ((state == S_EXEC) && !RST) begin
            WE_MEM = cur.op;
            WE_RF  = !cur.op;
        end
    end

    // ------------------------------------------------------------------
    // Sanity properties
    // ------------------------------------------------------------------
    a_we_exclusive : assert property (@(posedge CLK) !(WE_RF && WE_MEM));
    a_cnt_bound    : assert property (@(posedge CLK) disable iff (RST) fifo_cnt <= FULL_CNT);
    a_exec_to_done : assert property (@(posedge CLK) disable iff (RST)
                                      (state == S_EXEC) |=> (state == S_DONE));
    a_setup_to_ex  : assert property (@(posedge CLK) disable iff (RST)
                                      (state == S_SETUP) |=> (state == S_EXEC));

endmodule

// File: tb/tb_ls_sequencer.sv
module tb_ls_sequencer;
    localparam int DEPTH = 4;
    localparam int CNTW  = 16;

    logic            CLK = 1'b0;
    logic            RST;
    logic            halt;
    logic [4:0]      Ra;
    logic [4:0]      Rb;
    logic [4:0]      C;
    logic [4:0]      Rw;
    logic            WE_RF;
    logic            WE_MEM;
    logic            busy;
    logic            done;
    logic            done_op;
    logic [CNTW-1:0] retired;

    ls_sequencer_if cmd_if();

    ls_sequencer #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .cmd     (cmd_if),
        .halt    (halt),
        .Ra      (Ra),
        .Rb      (Rb),
        .C       (C),
        .Rw      (Rw),
        .WE_RF   (WE_RF),
        .WE_MEM  (WE_MEM),
        .busy    (busy),
        .done    (done),
        .done_op (done_op),
        .retired (retired)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       op;
        logic [4:0] rd;
        logic [4:0] rb;
        logic [4:0] off;
    } tcmd_t;

    typedef struct {
        logic        op;
        logic [4:0]  rd;
        logic [4:0]  rb;
        logic [4:0]  off;
        logic [63:0] base;      // value placed in reg[rb]
        logic [63:0] data;      // LOAD: word placed at exp_addr; STORE: value of reg[rd]
        logic [4:0]  exp_addr;  // address the access must land on
    } vec_t;

    // Datapath stand-in driven by the DUT selects, and the command-level reference.
    logic [63:0] regs     [32];
    logic [63:0] mem      [32];
    logic [63:0] ref_regs [32];
    logic [63:0] ref_mem  [32];
    tcmd_t       q[$];          // accepted, not yet completed (q[0] is in flight when ph >= 0)
    int          ph      = -1;  // -1 idle, 0 SETUP, 1 EXEC, 2 DONE of q[0]
    int          ref_ret = 0;
    bit          sb_on   = 1'b0;
    int          cnt_run  = 0;
    int          cnt_fail = 0;
    logic        s_done;
    logic        s_take;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        cnt_run++;
        if (got !== exp) begin
            cnt_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic set_reg(input int i, input logic [63:0] v);
        regs[i]     = v;
        ref_regs[i] = v;
    endtask

    task automatic set_mem(input int i, input logic [63:0] v);
        mem[i]     = v;
        ref_mem[i] = v;
    endtask

    // One clock: sample and score on the falling edge, then apply datapath
    // writes on the rising edge, and return 1 time unit after it.
    task automatic tick();
        logic [4:0] addr;
        logic [4:0] rw;
        logic [4:0] ra;
        logic       we_rf;
        logic       we_mem;
        logic       take;
        int         fifo_n;
        int         a;
        tcmd_t      c;
        tcmd_t      c_in;
        @(negedge CLK);
        s_done = done;
        take   = (cmd_if.cmd_valid === 1'b1) && (cmd_if.cmd_ready === 1'b1) && (RST === 1'b0);
        s_take = take;
        c_in   = '{cmd_if.cmd_op, cmd_if.cmd_rd, cmd_if.cmd_rb, cmd_if.cmd_off};
        addr   = regs[Rb][4:0] + C;
        rw     = Rw;
        ra     = Ra;
        we_rf  = WE_RF;
        we_mem = WE_MEM;

        if (sb_on) begin
            check("busy", busy, ph >= 0);
            check("done", done, ph == 2);
            check("retired", retired, CNTW'(ref_ret));
            if (ph >= 0 && q.size() > 0) begin
                c = q[0];
                check("Ra", Ra, c.rd);
                check("Rb", Rb, c.rb);
                check("C", C, c.off);
                check("Rw", Rw, c.rd);
                check("WE_MEM", WE_MEM, (ph == 1) && c.op && !RST);
                check("WE_RF", WE_RF, (ph == 1) && !c.op && !RST);
                if (ph == 2) check("done_op", done_op, c.op);
            end else begin
                check("idle_sel", {Ra, Rb, C, Rw}, 20'd0);
                check("idle_we", {WE_RF, WE_MEM}, 2'b00);
            end
        end

        fifo_n = (ph < 0) ? q.size() : q.size() - 1;
        if (ph == 2) begin
            c = q[0];
            a = (int'(ref_regs[c.rb][4:0]) + int'(c.off)) % 32;
            if (c.op) begin
                ref_mem[a] = ref_regs[c.rd];
                if (sb_on) check("store_effect", mem[a], ref_mem[a]);
            end else begin
                ref_regs[c.rd] = ref_mem[a];
                if (sb_on) check("load_effect", regs[c.rd], ref_regs[c.rd]);
            end
            ref_ret++;
            void'(q.pop_front());
        end
        if (RST === 1'b1) begin
            ph = -1;
            q.delete();
            ref_ret = 0;
            sb_on   = 1'b1;
        end else if (ph < 0 || ph == 2) begin
            ph = (fifo_n > 0 && !halt) ? 0 : -1;
        end else begin
            ph++;
        end
        if (take) q.push_back(c_in);

        @(posedge CLK);
        if (we_rf === 1'b1) regs[rw] = mem[addr];
        if (we_mem === 1'b1) mem[addr] = regs[ra];
        #1;
    endtask

    task automatic send(input logic op, input logic [4:0] rd, input logic [4:0] rb, input logic [4:0] off);
        int n;
        n = 0;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_rd    = rd;
        cmd_if.cmd_rb    = rb;
        cmd_if.cmd_off   = off;
        cmd_if.cmd_valid = 1'b1;
        do begin
            tick();
            n++;
        end while (!s_take && n < 20);
        cmd_if.cmd_valid = 1'b0;
        check("send_accept", s_take, 1'b1);
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!s_done && n < max);
    endtask

    task automatic wait_idle(input int max, output int dones);
        int n;
        n     = 0;
        dones = 0;
        while ((q.size() > 0 || ph >= 0) && n < max) begin
            tick();
            n++;
            if (s_done) dones++;
        end
        check("drain_complete", (q.size() == 0) && (ph < 0), 1'b1);
    endtask

    vec_t vt[7];

    initial begin
        int          n;
        int          d1;
        int          d2;
        int          dn;
        int          took;
        int          r0;
        logic [63:0] k;

        RST              = 1'b1;
        halt             = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 1'b0;
        cmd_if.cmd_rd    = '0;
        cmd_if.cmd_rb    = '0;
        cmd_if.cmd_off   = '0;
        for (int i = 0; i < 32; i++) begin
            set_reg(i, 64'd0);
            set_mem(i, 64'd0);
        end

        // Reset then idle.
        tick();
        tick();
        RST = 1'b0;
        #1;
        check("rst_cmd_ready", cmd_if.cmd_ready, 1'b1);
        check("rst_we", {WE_RF, WE_MEM}, 2'b00);
        check("rst_retired", retired, 16'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sel", {Ra, Rb, C, Rw}, 20'd0);

        // Single-command vectors: address formation, wrap, rd == rb, latency.
        vt[0] = '{1'b0, 5'd3,  5'd2,  5'd2,  64'd5,                  64'hA5,        5'd7};
        vt[1] = '{1'b0, 5'd6,  5'd2,  5'd5,  64'd30,                 64'h3333,      5'd3};
        vt[2] = '{1'b1, 5'd4,  5'd1,  5'd9,  64'd0,                  64'h1234,      5'd9};
        vt[3] = '{1'b1, 5'd0,  5'd31, 5'd31, 64'd31,                 64'hDEAD_BEEF, 5'd30};
        vt[4] = '{1'b0, 5'd31, 5'd0,  5'd0,  64'hFFFF_FFFF_FFFF_FFE1, 64'h77,        5'd1};
        vt[5] = '{1'b1, 5'd7,  5'd7,  5'd3,  64'd12,                 64'd12,        5'd15};
        vt[6] = '{1'b0, 5'd5,  5'd5,  5'd10, 64'd20,                 64'h5A5A,      5'd30};
        for (int i = 0; i < 7; i++) begin
            for (int a = 0; a < 32; a++) set_mem(a, 64'hF000_0000 + 64'(a));
            if (vt[i].op) set_reg(int'(vt[i].rd), vt[i].data);
            set_reg(int'(vt[i].rb), vt[i].base);
            if (!vt[i].op) set_mem(int'(vt[i].exp_addr), vt[i].data);
            send(vt[i].op, vt[i].rd, vt[i].rb, vt[i].off);
            wait_done(8, n);
            check($sformatf("vec%0d_latency", i), n, 4);
            if (vt[i].op) check($sformatf("vec%0d_mem", i), mem[vt[i].exp_addr], vt[i].data);
            else          check($sformatf("vec%0d_reg", i), regs[vt[i].rd], vt[i].data);
            check($sformatf("vec%0d_retired", i), retired, 16'(i + 1));
        end

        // STORE then LOAD back, pushed back to back: done pulses 3 cycles apart.
        set_reg(4, 64'h1234);
        set_reg(1, 64'd0);
        set_reg(6, 64'd0);
        set_mem(9, 64'd0);
        send(1'b1, 5'd4, 5'd1, 5'd9);
        send(1'b0, 5'd6, 5'd1, 5'd9);
        d1 = -1;
        d2 = -1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (s_done) begin
                if (d1 < 0) d1 = t;
                else if (d2 < 0) d2 = t;
            end
        end
        check("st_ld_first_done", d1, 3);
        check("st_ld_second_done", d2, 6);
        check("st_ld_mem9", mem[9], 64'h1234);
        check("st_ld_reg6", regs[6], 64'h1234);

        // Fill the queue while halted, then release; order matters through data dependencies.
        k = 64'hAAAA_5555_0000_1111;
        set_reg(10, 64'd100);
        set_reg(11, k);
        set_reg(12, 64'd0);
        set_reg(13, 64'd0);
        set_reg(14, 64'd0);
        set_mem(1, 64'd0);
        set_mem(4, 64'd0);
        halt = 1'b1;
        send(1'b1, 5'd11, 5'd10, 5'd0);
        send(1'b0, 5'd12, 5'd10, 5'd0);
        send(1'b1, 5'd12, 5'd13, 5'd1);
        send(1'b0, 5'd13, 5'd14, 5'd1);
        check("full_cmd_ready", cmd_if.cmd_ready, 1'b0);
        check("full_busy", busy, 1'b0);
        cmd_if.cmd_valid = 1'b1;
        took = 0;
        for (int t = 0; t < 3; t++) begin
            tick();
            if (s_take) took++;
        end
        cmd_if.cmd_valid = 1'b0;
        check("full_no_accept", took, 0);
        r0   = ref_ret;
        halt = 1'b0;
        wait_idle(40, dn);
        check("fill_dones", dn, 4);
        check("fill_retired", retired, 16'(r0 + 4));
        check("fill_mem4", mem[4], k);
        check("fill_reg12", regs[12], k);
        check("fill_mem1", mem[1], k);
        check("fill_reg13", regs[13], k);

        // Reset landing on EXEC of a STORE, with two more commands queued.
        set_reg(9, 64'd10);
        set_reg(8, 64'hDEAD);
        set_mem(10, 64'h55);
        send(1'b1, 5'd8, 5'd9, 5'd0);
        send(1'b0, 5'd1, 5'd9, 5'd0);
        send(1'b0, 5'd2, 5'd9, 5'd0);
        RST = 1'b1;
        #1;
        check("rst_exec_busy", busy, 1'b1);
        check("rst_exec_we_mem", WE_MEM, 1'b0);
        tick();
        RST = 1'b0;
        #1;
        check("rst_exec_mem10", mem[10], 64'h55);
        check("rst_exec_ready", cmd_if.cmd_ready, 1'b1);
        check("rst_exec_idle", busy, 1'b0);
        check("rst_exec_retired", retired, 16'd0);
        took = 0;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (s_done) took++;
        end
        check("rst_exec_no_done", took, 0);

        // Randomized traffic against the command-level reference.
        for (int i = 0; i < 32; i++) begin
            set_reg(i, {$urandom, $urandom});
            set_mem(i, {$urandom, $urandom});
        end
        for (int t = 0; t < 800; t++) begin
            cmd_if.cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_if.cmd_op    = 1'($urandom_range(0, 1));
            cmd_if.cmd_rd    = 5'($urandom_range(0, 31));
            cmd_if.cmd_rb    = 5'($urandom_range(0, 31));
            cmd_if.cmd_off   = 5'($urandom_range(0, 31));
            halt             = ($urandom_range(0, 6) == 0);
            tick();
        end
        cmd_if.cmd_valid = 1'b0;
        halt             = 1'b0;
        wait_idle(100, dn);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("final_reg%0d", i), regs[i], ref_regs[i]);
            check($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);
        end

        $display("[TB] %0d tests run, %0d failed", cnt_run, cnt_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time %0t reached limit 1000000 before the test ended", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
